cla_adder_pipe: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor built on the team's per-bit generate/propagate stage.
- Generalises the 4-bit PG block to N bits, with grouped lookahead and add/sub mode.
- Two register stages with a valid/ready handshake on both sides. Sits between operand sources and the ALU result path.

---
 rtl/cla_pkg.sv | 27 ++
 rtl/cla_group.sv | 41 ++++
 rtl/cla_adder_pipe.sv | 183 ++++++++++++++++++
 tb/tb_cla_adder_pipe.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
// Holds default geometry, the per-bit generate/propagate pair and the group P/G reduction.
package cla_pkg;

    localparam int CLA_N     = 16;
    localparam int CLA_GROUP = 4;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    // Reduce the low w bits of p/g to a single group propagate/generate pair.
    function automatic pg_t group_pg(input logic [63:0] p, input logic [63:0] g, input int w);
        pg_t r;
        r.p = 1'b1;
        r.g = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i < w) begin
                r.g = g[i] | (p[i] & r.g);
                r.p = r.p & p[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit lookahead cell: carries into each bit plus group P/G.
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = CLA_GROUP
) (
    input  logic [GROUP-1:0] p,
    input  logic [GROUP-1:0] g,
    input  logic             cin,
    output logic [GROUP-1:0] c,
    output logic             gp,
    output logic             gg
);

    pg_t  grp;
    logic term;
    logic prod;

    // Each carry is a flat sum-of-products over the lower bits and cin.
    always_comb begin
        c    = '0;
        term = 1'b0;
        prod = 1'b1;
        for (int i = 0; i < GROUP; i++) begin
            term = 1'b0;
            prod = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (prod & g[j]);
                prod = prod & p[j];
            end
            c[i] = term | (prod & cin);
        end
    end

    always_comb begin
        grp = group_pg(64'(p), 64'(g), GROUP);
        gp  = grp.p;
        gg  = grp.g;
    end

endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Optional macro CLA_ADDER_SATURATE_EN adds a per-beat sat input that clamps on signed overflow.
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int N     = CLA_N,
    parameter int GROUP = CLA_GROUP
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
`ifdef CLA_ADDER_SATURATE_EN
    input  logic         sat,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int NG = N / GROUP;

    logic s2_adv, s1_adv, accept, s2_load;

    logic          s1_valid_q, s1_valid_d;
    logic          s2_valid_q, s2_valid_d;
    pg_t [N-1:0]   s1_pg_q, s1_pg_d;
    logic          s1_c0_q, s1_c0_d;
    logic [NG-1:0] s1_gp_q, s1_gp_d;
    logic [NG-1:0] s1_gg_q, s1_gg_d;
    logic          s1_as_q, s1_as_d;
    logic          s1_bs_q, s1_bs_d;
`ifdef CLA_ADDER_SATURATE_EN
    logic          s1_sat_q, s1_sat_d;
`endif
    logic [N-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic [N-1:0]  b_eff, p_new, g_new;
    logic [NG-1:0] gp_new, gg_new;
    logic [N-1:0]  s1_p, s1_g, carry, sum_raw;
    logic [NG:0]   gc;
    logic          ovf_raw;
    logic [NG-1:0] inst_gp_unused, inst_gg_unused;
    pg_t           grp;

    always_comb begin
        s2_adv  = !s2_valid_q || out_ready;
        s1_adv  = !s1_valid_q || s2_adv;
        in_ready = s1_adv;
        accept  = in_valid && s1_adv;
        s2_load = s2_adv && s1_valid_q;
    end

    // Stage 1: per-bit and per-group P/G so S2 only has the carry tree left.
    always_comb begin
        b_eff = sub ? ~b : b;
        p_new = a ^ b_eff;
        g_new = a & b_eff;
        grp   = '0;
        for (int k = 0; k < NG; k++) begin
            grp       = group_pg(64'(p_new[k*GROUP +: GROUP]), 64'(g_new[k*GROUP +: GROUP]), GROUP);
            gp_new[k] = grp.p;
            gg_new[k] = grp.g;
        end
    end

    always_comb begin
        s1_valid_d = s1_adv ? accept : s1_valid_q;
        s1_pg_d    = s1_pg_q;
        s1_c0_d    = s1_c0_q;
        s1_gp_d    = s1_gp_q;
        s1_gg_d    = s1_gg_q;
        s1_as_d    = s1_as_q;
        s1_bs_d    = s1_bs_q;
`ifdef CLA_ADDER_SATURATE_EN
        s1_sat_d   = s1_sat_q;
`endif
        if (accept) begin
            for (int i = 0; i < N; i++) begin
                s1_pg_d[i].p = p_new[i];
                s1_pg_d[i].g = g_new[i];
            end
            s1_c0_d = sub | cin;
            s1_gp_d = gp_new;
            s1_gg_d = gg_new;
            s1_as_d = a[N-1];
            s1_bs_d = b_eff[N-1];
`ifdef CLA_ADDER_SATURATE_EN
            s1_sat_d = sat;
`endif
        end
    end

    // Stage 2: lookahead across groups, then carries inside each group.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            s1_p[i] = s1_pg_q[i].p;
            s1_g[i] = s1_pg_q[i].g;
        end
        gc[0] = s1_c0_q;
        for (int k = 0; k < NG; k++) begin
            gc[k+1] = s1_gg_q[k] | (s1_gp_q[k] & gc[k]);
        end
    end

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_group #(.GROUP(GROUP)) u_grp (
            .p   (s1_p[k*GROUP +: GROUP]),
            .g   (s1_g[k*GROUP +: GROUP]),
            .cin (gc[k]),
            .c   (carry[k*GROUP +: GROUP]),
            .gp  (inst_gp_unused[k]),
            .gg  (inst_gg_unused[k])
        );
    end

    always_comb begin
        sum_raw = s1_p ^ carry;
        // Like-signed operands with a differently-signed result; same as c[N-1]^c[N].
        ovf_raw = (s1_as_q == s1_bs_q) && (sum_raw[N-1] != s1_as_q);
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        if (s2_load) begin
            sum_d  = sum_raw;
            cout_d = gc[NG];
            ovf_d  = ovf_raw;
`ifdef CLA_ADDER_SATURATE_EN
            if (s1_sat_q && ovf_raw)
                sum_d = s1_as_q ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_pg_q    <= '0;
            s1_c0_q    <= 1'b0;
            s1_gp_q    <= '0;
            s1_gg_q    <= '0;
            s1_as_q    <= 1'b0;
            s1_bs_q    <= 1'b0;
`ifdef CLA_ADDER_SATURATE_EN
            s1_sat_q   <= 1'b0;
`endif
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_pg_q    <= s1_pg_d;
            s1_c0_q    <= s1_c0_d;
            s1_gp_q    <= s1_gp_d;
            s1_gg_q    <= s1_gg_d;
            s1_as_q    <= s1_as_d;
            s1_bs_q    <= s1_bs_d;
`ifdef CLA_ADDER_SATURATE_EN
            s1_sat_q   <= s1_sat_d;
`endif
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Scoreboard bench for cla_adder_pipe (N=16, GROUP=4); build with CLA_ADDER_SATURATE_EN to cover clamping.
module tb_cla_adder_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a_i = '0;
    logic [15:0] b_i = '0;
    logic        cin_i = 1'b0;
    logic        sub_i = 1'b0;
`ifdef CLA_ADDER_SATURATE_EN
    logic        sat_i = 1'b0;
`endif
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;
    int n_tx  = 0;
    int n_rx  = 0;
    logic [17:0] exp_q[$];

    cla_adder_pipe #(.N(16), .GROUP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
        .cin       (cin_i),
        .sub       (sub_i),
`ifdef CLA_ADDER_SATURATE_EN
        .sat       (sat_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: wide add of a and the effective b, packed as {cout, ovf, sum}.
    function automatic logic [17:0] model(input logic [15:0] va, input logic [15:0] vb,
                                          input logic vc, input logic vs, input logic vsat);
        logic [15:0] bp;
        logic [16:0] t;
        logic [15:0] s;
        logic        ov;
        bp = vs ? ~vb : vb;
        t  = {1'b0, va} + {1'b0, bp} + {16'd0, (vs | vc)};
        s  = t[15:0];
        ov = (va[15] == bp[15]) && (s[15] != va[15]);
        if (vsat && ov) s = va[15] ? 16'h8000 : 16'h7FFF;
        return {t[16], ov, s};
    endfunction

    // Called just after a rising edge; returns just after the edge that took the beat.
    task automatic send(input logic [15:0] va, input logic [15:0] vb,
                        input logic vc, input logic vs, input logic vsat);
        bit done;
        done = 0;
        a_i = va; b_i = vb; cin_i = vc; sub_i = vs;
`ifdef CLA_ADDER_SATURATE_EN
        sat_i = vsat;
`endif
        in_valid = 1'b1;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
`ifdef CLA_ADDER_SATURATE_EN
                exp_q.push_back(model(va, vb, vc, vs, vsat));
`else
                exp_q.push_back(model(va, vb, vc, vs, 1'b0));
`endif
                n_tx++;
                done = 1;
            end
            @(posedge clk);
            #1;
            if (!done && t >= 3) out_ready = 1'b1;
        end
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        logic [17:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("stale_beat", {14'd0, cout, ovf, sum}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("result", {14'd0, cout, ovf, sum}, {14'd0, e});
                n_rx++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int dropped;
        logic [15:0] edge_v [0:3];
        edge_v[0] = 16'h0000; edge_v[1] = 16'hFFFF; edge_v[2] = 16'h7FFF; edge_v[3] = 16'h8000;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_outputs", {14'd0, cout, ovf, sum}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk); #1;

        // Directed vectors, first one also checks two-cycle latency
        out_ready = 1'b1;
        send(16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1", {31'd0, out_valid}, 0);
        @(negedge clk);
        chk("lat_cycle2", {31'd0, out_valid}, 1);
        @(posedge clk); #1;

        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        send(16'h0005, 16'h0004, 1'b0, 1'b1, 1'b0);
        send(16'h0004, 16'h0005, 1'b0, 1'b1, 1'b0);
        send(16'h0004, 16'h0005, 1'b1, 1'b1, 1'b0);
        send(16'h1234, 16'h0FFF, 1'b1, 1'b0, 1'b0);
        send(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
`ifdef CLA_ADDER_SATURATE_EN
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        send(16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
        send(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);
`endif
        in_valid = 1'b0;
        drain();

        // Backpressure: two beats fill the pipe, then in_ready must stay low
        out_ready = 1'b0;
        send(16'h0001, 16'h0010, 1'b0, 1'b0, 1'b0);
        send(16'h0002, 16'h0010, 1'b0, 1'b0, 1'b0);
        a_i = 16'h0003; in_valid = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 0);
            chk("bp_hold", {15'd0, out_valid, sum}, {15'd0, 1'b1, 16'h0011});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(16'h0003, 16'h0010, 1'b0, 1'b0, 1'b0);
        send(16'h0004, 16'h0010, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        drain();

        // Random traffic with random consumer stalls
        for (int i = 0; i < 60; i++) begin
            logic [15:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            send(ra, rb, 1'($urandom), 1'($urandom), 1'($urandom));
        end
        in_valid = 1'b0;
        drain();

        // Reset with both stages full
        out_ready = 1'b0;
        send(16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0);
        send(16'h0030, 16'h0040, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_full", {30'd0, out_valid, in_ready}, {30'd0, 1'b1, 1'b0});
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 0);
        chk("midrst_outputs", {14'd0, cout, ovf, sum}, 0);
        dropped = exp_q.size();
        exp_q.delete();
        n_tx -= dropped;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            chk("post_rst_no_beat", {31'd0, out_valid}, 0);
        end
        @(posedge clk); #1;
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        drain();

        chk("beat_count", n_rx, n_tx);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
